// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared types and constants for the instruction fetch unit.
//   XLEN        : architectural word width
//   NOP_INSTR   : canonical no-op (addi x0,x0,0), shown on out_instr when idle
//   ifu_entry_t : prefetch FIFO entry {pc, instr}
//   align_word  : clears the two low address bits
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifu_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo -- first-word-fall-through prefetch buffer of ifu_entry_t.
//   DEPTH      : entries (power of two, 2..16)
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write i_push_data at the tail
//   i_pop      : retire the head entry
//   i_flush    : discard all entries (wins over push/pop)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_count    : number of entries held (0..DEPTH)
//   o_head     : head entry, valid whenever !o_empty
// ---------------------------------------------------------------------------
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  ifu_entry_t               i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output ifu_entry_t               o_head
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    ifu_entry_t     r_mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (o_count == (PTR_W+1)'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit -- credit-based instruction prefetcher.
// Issues sequential word fetches, buffers returned words with their PCs in a
// DEPTH-entry FWFT FIFO and presents them to decode. A redirect flushes the
// buffer, retargets fetch and drops the responses still in flight.
//   DEPTH, RESET_PC        : FIFO depth, first fetch address after reset
//   clk, reset             : clock, asynchronous active-high reset
//   imem_req_valid/addr/ready : fetch request channel
//   imem_rsp_valid/data    : in-order instruction return channel
//   redirect_valid/pc      : taken branch/jump, flush and refetch
//   out_valid/pc/instr/ready : decode channel
//   stall_cycles           : only with IFU_STALL_CNT_EN defined; saturating
//                            count of cycles where decode waits on fetch
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_ready
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [XLEN-1:0] stall_cycles
`endif
);

    localparam int               CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_rsp_pc;       // PC owed to the next kept response
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;      // stale responses still to be dropped

    logic [CNT_W-1:0] w_outstanding_nxt;
    logic [CNT_W-1:0] w_discard_nxt;
    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W:0]   w_credits_used;
    logic             w_req_fire;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    ifu_entry_t       w_push_entry;
    ifu_entry_t       w_head;

    // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
    assign w_credits_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = (w_credits_used < (CNT_W+1)'(DEPTH)) && !redirect_valid && !reset;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop   = imem_rsp_valid && (r_discard != '0);
    // A response arriving in the redirect cycle is stale too; the flush eats it.
    assign w_push       = imem_rsp_valid && !w_rsp_drop && !redirect_valid;
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    assign out_valid = !w_fifo_empty && !redirect_valid;
    assign out_pc    = w_head.pc;
    assign out_instr = w_fifo_empty ? NOP_INSTR : w_head.instr;
    assign w_pop     = out_valid && out_ready;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;

        if (w_req_fire && !imem_rsp_valid)      w_outstanding_nxt = r_outstanding + ONE;
        else if (!w_req_fire && imem_rsp_valid) w_outstanding_nxt = r_outstanding - ONE;

        // Everything still in flight after this cycle belongs to the old path.
        if (redirect_valid)  w_discard_nxt = r_outstanding - CNT_W'(imem_rsp_valid);
        else if (w_rsp_drop) w_discard_nxt = r_discard - ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;

            if (redirect_valid)  r_fetch_pc <= align_word(redirect_pc);
            else if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;

            // Kept responses after a redirect start at the new target.
            if (redirect_valid)  r_rsp_pc <= align_word(redirect_pc);
            else if (w_push)     r_rsp_pc <= r_rsp_pc + 32'd4;
        end
    end

    ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_head      (w_head)
    );

    // The credit scheme must make a push into a full, non-popping FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_fifo_full && !w_pop));

`ifdef IFU_STALL_CNT_EN
    logic [XLEN-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          r_stall_cnt <= '0;
        else if (out_ready && !out_valid && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
